// File: rtl/raycast_slice_sequencer_if.sv
// Handshake and buffer-write bundle between the slice sequencer, the shared
// raycaster/distance core and the column distance buffer.
// master: the sequencer side (issues rays, writes the column buffer).
// slave : the environment side (frame control, raycaster responses).
interface raycast_slice_sequencer_if;
  // Frame control
  logic        frame_start;
  logic [8:0]  player_angle;
  logic        busy;
  logic        frame_done;

  // Ray request channel
  logic        ray_valid;
  logic        ray_ready;
  logic [7:0]  ray_col;
  logic [8:0]  ray_angle_int;
  logic [9:0]  ray_angle_frac;

  // Distance return channel
  logic        dist_valid;
  logic [20:0] dist_in;

  // Column buffer write port
  logic        col_we;
  logic [7:0]  col_addr;
  logic [20:0] col_dist;

  modport master (
    input  frame_start,
    input  player_angle,
    input  ray_ready,
    input  dist_valid,
    input  dist_in,
    output busy,
    output frame_done,
    output ray_valid,
    output ray_col,
    output ray_angle_int,
    output ray_angle_frac,
    output col_we,
    output col_addr,
    output col_dist
  );

  modport slave (
    output frame_start,
    output player_angle,
    output ray_ready,
    output dist_valid,
    output dist_in,
    input  busy,
    input  frame_done,
    input  ray_valid,
    input  ray_col,
    input  ray_angle_int,
    input  ray_angle_frac,
    input  col_we,
    input  col_addr,
    input  col_dist
  );
endinterface

// File: rtl/raycast_slice_sequencer.sv
// Per-frame raycasting controller: walks every screen column, issues one ray
// per column with its fixed-point angle (whole degrees + millidegrees), waits
// for the distance and writes it into the column buffer.
module raycast_slice_sequencer #(
  parameter int unsigned NUM_SLICES   = 160,
  parameter int unsigned HALF_FOV_DEG = 30,
  parameter int unsigned STEP_MILLI   = 375
) (
  input logic                        i_clock,
  input logic                        i_resetn,
  raycast_slice_sequencer_if.master  io_bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [7:0]  LAST_COL   = 8'(NUM_SLICES - 1);
  localparam logic [9:0]  HALF_FOV   = 10'(HALF_FOV_DEG);
  localparam logic [10:0] STEP       = 11'(STEP_MILLI);
  localparam logic [10:0] MILLI_WRAP = 11'd1000;
  localparam logic [8:0]  LAST_DEG   = 9'd359;

  // State and ray payload
  logic [2:0]  r_state;
  logic [7:0]  r_col;
  logic [8:0]  r_int;
  logic [9:0]  r_frac;

  // Registered outputs
  logic        r_ray_valid;
  logic        r_col_we;
  logic        r_frame_done;
  logic        r_busy;
  logic [7:0]  r_col_addr;
  logic [20:0] r_col_dist;

  // Next-state values
  logic [2:0]  w_state_d;
  logic [7:0]  w_col_d;
  logic [8:0]  w_int_d;
  logic [9:0]  w_frac_d;
  logic        w_capture;

  // Start-angle and angle-advance datapath
  logic [9:0]  w_pa;
  logic [8:0]  w_start;
  logic [10:0] w_sum;
  logic        w_carry;
  logic [9:0]  w_frac_adv;
  logic [8:0]  w_int_adv;

  // Out-of-range headings are treated as 0 before subtracting the half FOV
  assign w_pa = (io_bus.player_angle >= 9'd360) ? 10'd0 : {1'b0, io_bus.player_angle};

  // Leftmost ray angle, wrapped into 0..359
  assign w_start = (w_pa >= HALF_FOV) ? 9'(w_pa - HALF_FOV)
                                      : 9'(w_pa + 10'd360 - HALF_FOV);

  // Incremental step: add the millidegree increment and carry into degrees
  assign w_sum      = {1'b0, r_frac} + STEP;
  assign w_carry    = (w_sum >= MILLI_WRAP);
  assign w_frac_adv = w_carry ? 10'(w_sum - MILLI_WRAP) : w_sum[9:0];
  assign w_int_adv  = !w_carry          ? r_int :
                      (r_int == LAST_DEG) ? 9'd0  : r_int + 9'd1;

  // Next-state and payload update for the slice sequence
  always_comb begin
    w_state_d = r_state;
    w_col_d   = r_col;
    w_int_d   = r_int;
    w_frac_d  = r_frac;
    w_capture = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.frame_start) begin
          w_state_d = S_ISSUE;
          w_col_d   = 8'd0;
          w_int_d   = w_start;
          w_frac_d  = 10'd0;
        end
      end
      S_ISSUE: begin
        // ray_valid is high throughout ISSUE, so ready alone completes the handshake
        if (io_bus.ray_ready) begin
          w_state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (io_bus.dist_valid) begin
          w_state_d = S_WRITE;
          w_capture = 1'b1;
        end
      end
      S_WRITE: begin
        if (r_col == LAST_COL) begin
          w_state_d = S_DONE;
        end else begin
          w_state_d = S_ISSUE;
          w_col_d   = r_col + 8'd1;
          w_int_d   = w_int_adv;
          w_frac_d  = w_frac_adv;
        end
      end
      S_DONE: begin
        w_state_d = S_IDLE;
      end
      default: begin
        w_state_d = S_IDLE;
      end
    endcase
  end

  // State and ray payload registers
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state <= S_IDLE;
      r_col   <= 8'd0;
      r_int   <= 9'd0;
      r_frac  <= 10'd0;
    end else begin
      r_state <= w_state_d;
      r_col   <= w_col_d;
      r_int   <= w_int_d;
      r_frac  <= w_frac_d;
    end
  end

  // Status strobes registered from the next state so they align with it
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_ray_valid  <= 1'b0;
      r_col_we     <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_ray_valid  <= (w_state_d == S_ISSUE);
      r_col_we     <= (w_state_d == S_WRITE);
      r_frame_done <= (w_state_d == S_DONE);
      r_busy       <= (w_state_d != S_IDLE);
    end
  end

  // Column buffer address/data, loaded as the distance is accepted
  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_col_addr <= 8'd0;
      r_col_dist <= 21'd0;
    end else if (w_capture) begin
      r_col_addr <= r_col;
      r_col_dist <= io_bus.dist_in;
    end
  end

  assign io_bus.ray_valid      = r_ray_valid;
  assign io_bus.ray_col        = r_col;
  assign io_bus.ray_angle_int  = r_int;
  assign io_bus.ray_angle_frac = r_frac;
  assign io_bus.col_we         = r_col_we;
  assign io_bus.col_addr       = r_col_addr;
  assign io_bus.col_dist       = r_col_dist;
  assign io_bus.busy           = r_busy;
  assign io_bus.frame_done     = r_frame_done;

endmodule

// File: tb/tb_raycast_slice_sequencer.sv
// Directed bench for raycast_slice_sequencer: a responder plays the raycaster
// (optional backpressure, latency and stray distance pulses) and a monitor
// checks every ray angle, payload hold and column write against a model.
module tb_raycast_slice_sequencer;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  raycast_slice_sequencer_if sif ();

  raycast_slice_sequencer #(
    .NUM_SLICES   (160),
    .HALF_FOV_DEG (30),
    .STEP_MILLI   (375)
  ) dut (
    .i_clock  (clk),
    .i_resetn (resetn),
    .io_bus   (sif)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Responder controls
  bit          rdy_rand = 1'b0;
  bit          lat_rand = 1'b0;
  bit          spur_en  = 1'b0;
  int          rdy_cnt  = 0;
  int          lat_cnt  = 0;
  bit          hs_prev  = 1'b0;
  int          hs_col   = 0;
  logic [20:0] exp_dist [256];

  // Monitor state
  bit          mon_en = 1'b0;
  int          exp_start = 0;
  int          exp_next_col = 0;
  int          exp_wr_col = 0;
  int          we_cnt = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          start_cyc = 0;
  int          seen_ang [256];
  logic        prev_valid = 1'b0;
  logic        prev_hs = 1'b0;
  logic [26:0] prev_pl = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Raycaster model: drives ready and returns one distance per accepted ray
  initial begin
    sif.ray_ready  = 1'b1;
    sif.dist_valid = 1'b0;
    sif.dist_in    = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!resetn) begin
        lat_cnt = 0;
        rdy_cnt = 0;
        hs_prev = 1'b0;
        sif.dist_valid = 1'b0;
        sif.ray_ready  = 1'b1;
      end else begin
        sif.dist_valid = 1'b0;
        if (hs_prev) lat_cnt = lat_rand ? int'($urandom_range(20, 1)) : 1;
        if (lat_cnt > 0) begin
          lat_cnt--;
          if (lat_cnt == 0) begin
            exp_dist[hs_col] = 21'($urandom);
            sif.dist_in    = exp_dist[hs_col];
            sif.dist_valid = 1'b1;
          end
        end else if (spur_en && $urandom_range(3, 0) == 0) begin
          sif.dist_in    = 21'($urandom);
          sif.dist_valid = 1'b1;
        end
        if (sif.ray_valid) begin
          if (rdy_cnt > 0) begin
            sif.ray_ready = 1'b0;
            rdy_cnt--;
          end else begin
            sif.ray_ready = 1'b1;
          end
        end else begin
          sif.ray_ready = !rdy_rand;
          rdy_cnt = rdy_rand ? int'($urandom_range(5, 0)) : 0;
        end
        hs_prev = sif.ray_valid && sif.ray_ready;
        hs_col  = int'(sif.ray_col);
      end
    end
  end

  // Monitor, sampling mid-cycle
  initial begin
    logic [26:0] pl;
    int          m;
    int          got_ang;
    forever begin
      @(negedge clk);
      pl = {sif.ray_col, sif.ray_angle_int, sif.ray_angle_frac};
      if (resetn && mon_en) begin
        if (sif.ray_valid && prev_valid && !prev_hs)
          check_eq("payload_hold", 32'(pl), 32'(prev_pl));
        if (sif.ray_valid && sif.ray_ready) begin
          check_eq("ray_col", 32'(sif.ray_col), 32'(exp_next_col));
          m = (exp_start * 1000 + exp_next_col * 375) % 360000;
          got_ang = int'(sif.ray_angle_int) * 1000 + int'(sif.ray_angle_frac);
          check_eq("ray_angle", 32'(got_ang), 32'(m));
          seen_ang[sif.ray_col] = got_ang;
          exp_next_col++;
        end
        if (sif.col_we) begin
          check_eq("col_addr", 32'(sif.col_addr), 32'(exp_wr_col));
          check_eq("col_dist", 32'(sif.col_dist), 32'(exp_dist[sif.col_addr]));
          we_cnt++;
          exp_wr_col++;
        end
        if (sif.frame_done) begin
          check_eq("busy_at_done", 32'(sif.busy), 32'd1);
          done_cnt++;
          done_cyc = cyc;
        end
      end
      prev_valid = sif.ray_valid;
      prev_hs    = sif.ray_valid && sif.ray_ready;
      prev_pl    = pl;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_strobes"},
             32'({sif.ray_valid, sif.col_we, sif.frame_done, sif.busy}), 32'd0);
    check_eq({tag, "_payload"},
             32'({sif.ray_col, sif.ray_angle_int, sif.ray_angle_frac}), 32'd0);
    check_eq({tag, "_col_addr"}, 32'(sif.col_addr), 32'd0);
    check_eq({tag, "_col_dist"}, 32'(sif.col_dist), 32'd0);
  endtask

  task automatic start_frame(input int ang);
    int a;
    a = (ang >= 360) ? 0 : ang;
    exp_start    = (a >= 30) ? a - 30 : a + 330;
    exp_next_col = 0;
    exp_wr_col   = 0;
    we_cnt       = 0;
    done_cnt     = 0;
    for (int i = 0; i < 256; i++) seen_ang[i] = -1;
    @(posedge clk);
    #1;
    sif.player_angle = 9'(ang);
    sif.frame_start  = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    sif.frame_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check_eq("done_in_budget", 32'(done_cnt != 0), 32'd1);
  endtask

  task automatic check_ang(input string tag, input int col, input int exp_milli);
    check_eq(tag, 32'(seen_ang[col]), 32'(exp_milli));
  endtask

  initial begin
    int n;
    bit found;
    sif.frame_start  = 1'b0;
    sif.player_angle = '0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("rst");
    @(negedge clk);
    resetn = 1'b1;
    mon_en = 1'b1;

    // Stray distance pulses while idle must not write
    spur_en = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_eq("idle_no_write", 32'(we_cnt), 32'd0);
    check_eq("idle_not_busy", 32'(sif.busy), 32'd0);
    spur_en = 1'b0;

    // Heading 90, ready tied high, distance one cycle after accept
    start_frame(90);
    check_eq("valid_n1", 32'(sif.ray_valid), 32'd1);
    check_eq("busy_n1", 32'(sif.busy), 32'd1);
    wait_done(2000);
    check_eq("frame_cycles", 32'(done_cyc - start_cyc), 32'd481);
    check_eq("busy_after_done", 32'({sif.busy, sif.frame_done}), 32'd0);
    check_eq("we_count_90", 32'(we_cnt), 32'd160);
    check_eq("done_count_90", 32'(done_cnt), 32'd1);
    check_ang("ang90_c0", 0, 60000);
    check_ang("ang90_c1", 1, 60375);
    check_ang("ang90_c8", 8, 63000);
    check_ang("ang90_c159", 159, 119625);

    // Heading 10 with backpressure, long latency and stray pulses
    rdy_rand = 1'b1;
    lat_rand = 1'b1;
    spur_en  = 1'b1;
    start_frame(10);
    wait_done(10000);
    check_eq("we_count_10", 32'(we_cnt), 32'd160);
    check_eq("done_count_10", 32'(done_cnt), 32'd1);
    check_ang("ang10_c0", 0, 340000);
    check_ang("ang10_c53", 53, 359875);
    check_ang("ang10_c54", 54, 250);
    check_ang("ang10_c159", 159, 39625);

    // Boundary headings around the half field of view
    rdy_rand = 1'b0;
    lat_rand = 1'b0;
    spur_en  = 1'b0;
    start_frame(30);
    wait_done(2000);
    check_ang("ang30_c0", 0, 0);
    start_frame(29);
    wait_done(2000);
    check_ang("ang29_c0", 0, 359000);
    check_ang("ang29_c3", 3, 125);

    // frame_start during a frame is ignored
    rdy_rand = 1'b1;
    lat_rand = 1'b1;
    spur_en  = 1'b1;
    start_frame(45);
    n = 0;
    while (!(sif.ray_valid && sif.ray_col == 8'd40) && n < 8000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("reach_col40", 32'(sif.ray_col), 32'd40);
    sif.player_angle = 9'd200;
    sif.frame_start  = 1'b1;
    @(posedge clk);
    #1;
    sif.frame_start = 1'b0;
    wait_done(10000);
    repeat (30) @(posedge clk);
    #1;
    check_eq("single_done", 32'(done_cnt), 32'd1);
    check_eq("no_restart", 32'({sif.busy, sif.ray_valid}), 32'd0);
    check_ang("ang45_c40", 40, 30000);
    check_ang("ang45_c159", 159, 74625);

    // Asynchronous reset while waiting on column 77
    start_frame(90);
    found = 1'b0;
    n = 0;
    while (!found && n < 8000) begin
      @(negedge clk);
      n++;
      found = (sif.ray_col == 8'd77) && sif.busy && !sif.ray_valid && !sif.col_we &&
              !sif.frame_done;
    end
    check_eq("reach_wait77", 32'(found), 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_eq("abort_no_done", 32'(done_cnt), 32'd0);
    check_eq("abort_idle", 32'(sif.busy), 32'd0);
    start_frame(90);
    wait_done(10000);
    check_eq("we_count_restart", 32'(we_cnt), 32'd160);
    check_ang("restart_c0", 0, 60000);
    check_ang("restart_c77", 77, 88875);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
